// File: rtl/aes_bist_pkg.sv
// Shared types and helpers for the AES known-answer self-test sequencer.
package aes_bist_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_KEY_MAX_W = 256;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    CRST,
    CSTART,
    WAIT,
    CHECK,
    NEXT,
    FINISH
  } bist_state_t;

  function automatic logic [1:0] key_w_to_mode(input int key_w);
    case (key_w)
      128:     return 2'd0;
      192:     return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic bit key_w_legal(input int key_w);
    return (key_w == 128) || (key_w == 192) || (key_w == 256);
  endfunction

endpackage

// File: rtl/aes_bist_wdog.sv
// Phase watchdog: reloads on clear, counts down while enabled, flags expiry at zero.
module aes_bist_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expire = en && (count == '0);

endmodule

// File: rtl/aes_bist_ctrl.sv
// Known-answer BIST sequencer: walks a vector ROM, runs encipher then decipher on
// the AES core per entry and records pass/fail, error count and first failure.
module aes_bist_ctrl
  import aes_bist_pkg::*;
#(
  parameter int KEY_W        = 256,
  parameter int NUM_VEC      = 16,
  parameter int TIMEOUT      = 64,
  parameter int STOP_ON_FAIL = 0,
  localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int EW = $clog2(NUM_VEC) + 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  output logic [AW-1:0]            vec_addr,
  input  logic [AES_BLK_W-1:0]     vec_pt,
  input  logic [AES_BLK_W-1:0]     vec_ct,
  input  logic [KEY_W-1:0]         vec_key,
  output logic                     core_reset,
  output logic                     core_start,
  output logic                     core_enc_dec,
  output logic [1:0]               core_mode,
  output logic [AES_KEY_MAX_W-1:0] core_key,
  output logic [AES_BLK_W-1:0]     core_data_in,
  input  logic [AES_BLK_W-1:0]     core_data_out,
  input  logic                     core_done,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [EW-1:0]            err_count,
  output logic [AW-1:0]            fail_idx,
  output logic                     fail_phase,
  output logic                     timeout_flag
);

  if (!key_w_legal(KEY_W)) begin : g_key_w_check
    $error("aes_bist_ctrl: KEY_W must be 128, 192 or 256");
  end

  localparam bit STOP = (STOP_ON_FAIL != 0);

  bist_state_t          state;
  logic [AW-1:0]        idx;
  logic [AES_BLK_W-1:0] pt_r;
  logic [AES_BLK_W-1:0] ct_r;
  logic [AES_BLK_W-1:0] check_ref;
  logic                 mismatch;
  logic                 wdog_expire;
  logic                 log_err;

  assign core_mode = key_w_to_mode(KEY_W);

  // Encipher result is checked against ct, decipher result against pt.
  assign check_ref = core_enc_dec ? pt_r : ct_r;
  assign mismatch  = (core_data_out != check_ref);
  assign log_err   = ((state == CHECK) && mismatch) ||
                     ((state == WAIT) && !core_done && wdog_expire);

  aes_bist_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == CSTART),
    .en      (state == WAIT),
    .expire  (wdog_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      pt_r         <= '0;
      ct_r         <= '0;
      vec_addr     <= '0;
      core_reset   <= 1'b1;
      core_start   <= 1'b0;
      core_enc_dec <= 1'b0;
      core_key     <= '0;
      core_data_in <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_idx     <= '0;
      fail_phase   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      core_reset <= 1'b0;
      core_start <= 1'b0;

      // Saturating error count; the first error pins down where it happened.
      if (log_err) begin
        if (!(&err_count)) err_count <= err_count + EW'(1);
        if (err_count == '0) begin
          fail_idx   <= idx;
          fail_phase <= core_enc_dec;
        end
      end

      case (state)
        IDLE: begin
          if (run) begin
            idx          <= '0;
            vec_addr     <= '0;
            err_count    <= '0;
            pass         <= 1'b0;
            done         <= 1'b0;
            timeout_flag <= 1'b0;
            fail_idx     <= '0;
            fail_phase   <= 1'b0;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          vec_addr <= idx;
          state    <= LOAD;
        end
        LOAD: begin
          pt_r         <= vec_pt;
          ct_r         <= vec_ct;
          core_key     <= AES_KEY_MAX_W'(vec_key);
          core_data_in <= vec_pt;
          core_enc_dec <= 1'b0;
          core_reset   <= 1'b1;
          state        <= CRST;
        end
        CRST: begin
          core_start <= 1'b1;
          state      <= CSTART;
        end
        CSTART: begin
          state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            state <= CHECK;
          end else if (wdog_expire) begin
            timeout_flag <= 1'b1;
            state        <= STOP ? FINISH : NEXT;
          end
        end
        CHECK: begin
          if (mismatch && STOP) begin
            state <= FINISH;
          end else if (!core_enc_dec) begin
            core_enc_dec <= 1'b1;
            core_data_in <= ct_r;
            core_reset   <= 1'b1;
            state        <= CRST;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (idx == AW'(NUM_VEC - 1)) begin
            state <= FINISH;
          end else begin
            idx      <= idx + AW'(1);
            vec_addr <= idx + AW'(1);
            state    <= FETCH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Scoreboard bench for aes_bist_ctrl: three configurations driving a behavioural core and ROM.
module tb_aes_bist_ctrl;

  localparam logic [127:0] FIPS_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] FIPS_K128  = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] FIPS_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  // Core latency per instance; 7 on instance 0 lands core_done on the watchdog's last WAIT cycle.
  localparam int LAT [3] = '{7, 3, 2};

  typedef struct {
    int   inst;
    logic pass;
    int   err;
    int   fidx;
    logic fphase;
    logic tflag;
    int   starts;
    int   maxaddr;
  } exp_t;

  logic clk;
  logic reset_n;
  logic run [3];
  logic hang [3];

  logic [127:0] vec_pt [3];
  logic [127:0] vec_ct [3];
  logic [255:0] vec_key_a, vec_key_c;
  logic [127:0] vec_key_b;
  logic [1:0]   vec_addr_a, vec_addr_c, fidx_a, fidx_c;
  logic [0:0]   vec_addr_b, fidx_b;
  logic [3:0]   err_a, err_c;
  logic [1:0]   err_b;

  logic         core_reset [3];
  logic         core_start [3];
  logic         core_enc_dec [3];
  logic [1:0]   core_mode [3];
  logic [255:0] core_key [3];
  logic [127:0] core_data_in [3];
  logic [127:0] core_data_out [3];
  logic         core_done [3];
  logic         busy [3];
  logic         done [3];
  logic         pass [3];
  logic         fail_phase [3];
  logic         timeout_flag [3];

  logic [127:0] rom_pt [3][4];
  logic [127:0] rom_ct [3][4];
  logic [255:0] rom_key [3][4];

  int v_addr [3];
  int v_err [3];
  int v_fidx [3];

  int   checks;
  int   failures;
  exp_t sb [$];
  int   start_base [3];

  int cyc;
  int nstart [3];
  int last_start [3];
  int gap [3];
  int maxaddr [3];

  logic [3:0]   ccnt [3];
  logic         cbusy [3];
  logic [127:0] cdin [3];
  logic [255:0] ckey [3];
  logic         cdec [3];

  aes_bist_ctrl #(.KEY_W(256), .NUM_VEC(4), .TIMEOUT(8), .STOP_ON_FAIL(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .run(run[0]), .vec_addr(vec_addr_a),
    .vec_pt(vec_pt[0]), .vec_ct(vec_ct[0]), .vec_key(vec_key_a),
    .core_reset(core_reset[0]), .core_start(core_start[0]), .core_enc_dec(core_enc_dec[0]),
    .core_mode(core_mode[0]), .core_key(core_key[0]), .core_data_in(core_data_in[0]),
    .core_data_out(core_data_out[0]), .core_done(core_done[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .err_count(err_a), .fail_idx(fidx_a),
    .fail_phase(fail_phase[0]), .timeout_flag(timeout_flag[0])
  );

  aes_bist_ctrl #(.KEY_W(128), .NUM_VEC(1), .TIMEOUT(64), .STOP_ON_FAIL(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .run(run[1]), .vec_addr(vec_addr_b),
    .vec_pt(vec_pt[1]), .vec_ct(vec_ct[1]), .vec_key(vec_key_b),
    .core_reset(core_reset[1]), .core_start(core_start[1]), .core_enc_dec(core_enc_dec[1]),
    .core_mode(core_mode[1]), .core_key(core_key[1]), .core_data_in(core_data_in[1]),
    .core_data_out(core_data_out[1]), .core_done(core_done[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .err_count(err_b), .fail_idx(fidx_b),
    .fail_phase(fail_phase[1]), .timeout_flag(timeout_flag[1])
  );

  aes_bist_ctrl #(.KEY_W(256), .NUM_VEC(4), .TIMEOUT(16), .STOP_ON_FAIL(1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .run(run[2]), .vec_addr(vec_addr_c),
    .vec_pt(vec_pt[2]), .vec_ct(vec_ct[2]), .vec_key(vec_key_c),
    .core_reset(core_reset[2]), .core_start(core_start[2]), .core_enc_dec(core_enc_dec[2]),
    .core_mode(core_mode[2]), .core_key(core_key[2]), .core_data_in(core_data_in[2]),
    .core_data_out(core_data_out[2]), .core_done(core_done[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .err_count(err_c), .fail_idx(fidx_c),
    .fail_phase(fail_phase[2]), .timeout_flag(timeout_flag[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in cipher: known FIPS-197 pairs answer exactly, anything else is a keyed XOR.
  function automatic logic [127:0] mix(input logic [255:0] k);
    return k[255:128] ^ {k[126:0], k[127]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
  endfunction

  function automatic logic [127:0] model_aes(input logic [255:0] k, input logic [127:0] d,
                                             input logic dec);
    if (!dec && k == FIPS_K256 && d == FIPS_PT)    return FIPS_CT256;
    if (dec  && k == FIPS_K256 && d == FIPS_CT256) return FIPS_PT;
    if (!dec && k == FIPS_K128 && d == FIPS_PT)    return FIPS_CT128;
    if (dec  && k == FIPS_K128 && d == FIPS_CT128) return FIPS_PT;
    return d ^ mix(k);
  endfunction

  always_ff @(posedge clk) begin
    vec_pt[0] <= rom_pt[0][vec_addr_a];
    vec_ct[0] <= rom_ct[0][vec_addr_a];
    vec_key_a <= rom_key[0][vec_addr_a];
    vec_pt[1] <= rom_pt[1][vec_addr_b];
    vec_ct[1] <= rom_ct[1][vec_addr_b];
    vec_key_b <= rom_key[1][vec_addr_b][127:0];
    vec_pt[2] <= rom_pt[2][vec_addr_c];
    vec_ct[2] <= rom_ct[2][vec_addr_c];
    vec_key_c <= rom_key[2][vec_addr_c];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (core_reset[i]) begin
        core_done[i] <= 1'b0;
        cbusy[i]     <= 1'b0;
        ccnt[i]      <= '0;
      end else if (core_start[i]) begin
        cbusy[i]     <= !hang[i];
        ccnt[i]      <= 4'(LAT[i]);
        cdin[i]      <= core_data_in[i];
        ckey[i]      <= core_key[i];
        cdec[i]      <= core_enc_dec[i];
        core_done[i] <= 1'b0;
      end else if (cbusy[i]) begin
        if (ccnt[i] == 4'd1) begin
          core_done[i]     <= 1'b1;
          core_data_out[i] <= model_aes(ckey[i], cdin[i], cdec[i]);
          cbusy[i]         <= 1'b0;
        end
        ccnt[i] <= ccnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    v_addr[0] = int'(vec_addr_a);
    v_addr[1] = int'(vec_addr_b);
    v_addr[2] = int'(vec_addr_c);
    v_err[0]  = int'(err_a);
    v_err[1]  = int'(err_b);
    v_err[2]  = int'(err_c);
    v_fidx[0] = int'(fidx_a);
    v_fidx[1] = int'(fidx_b);
    v_fidx[2] = int'(fidx_c);
  end

  always_ff @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (core_start[i]) begin
        nstart[i]     <= nstart[i] + 1;
        gap[i]        <= cyc - last_start[i];
        last_start[i] <= cyc;
      end
      if (run[i] && !busy[i]) maxaddr[i] <= 0;
      else if (v_addr[i] > maxaddr[i]) maxaddr[i] <= v_addr[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mkExp(input int inst, input logic p, input int err, input int fi,
                                 input logic fph, input logic tf, input int st, input int ma);
    exp_t e;
    e.inst = inst; e.pass = p; e.err = err; e.fidx = fi;
    e.fphase = fph; e.tflag = tf; e.starts = st; e.maxaddr = ma;
    return e;
  endfunction

  task automatic applyStimulus(input exp_t e);
    @(posedge clk); #1;
    start_base[e.inst] = nstart[e.inst];
    sb.push_back(e);
    run[e.inst] = 1'b1;
    @(posedge clk); #1;
    run[e.inst] = 1'b0;
  endtask

  task automatic waitResult(input int inst);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    checkOutput("busy_run", busy[inst], 1'b1);
    while (done[inst] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done[inst] !== 1'b1) begin
      checkOutput("done_wait", done[inst], 1'b1);
      sb.delete();
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("pass", pass[inst], e.pass);
      checkOutput("err_count", v_err[inst], e.err);
      checkOutput("fail_idx", v_fidx[inst], e.fidx);
      checkOutput("fail_phase", fail_phase[inst], e.fphase);
      checkOutput("timeout_flag", timeout_flag[inst], e.tflag);
      checkOutput("busy_end", busy[inst], 1'b0);
      checkOutput("core_starts", nstart[inst] - start_base[inst], e.starts);
      checkOutput("max_vec_addr", maxaddr[inst], e.maxaddr);
    end
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_flags"},
                {core_reset[0], core_start[0], core_enc_dec[0], busy[0], done[0], pass[0],
                 fail_phase[0], timeout_flag[0]}, 8'h80);
    checkOutput({pfx, "_err"}, v_err[0], 0);
    checkOutput({pfx, "_addr"}, v_addr[0], 0);
    checkOutput({pfx, "_fidx"}, v_fidx[0], 0);
    checkOutput({pfx, "_key"}, core_key[0], 0);
    checkOutput({pfx, "_din"}, core_data_in[0], 0);
    checkOutput({pfx, "_mode"}, core_mode[0], 2'd2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run[i]  = 1'b0;
      hang[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      rom_key[0][i] = FIPS_K256 ^ {32{8'(i)}};
      rom_pt[0][i]  = FIPS_PT ^ {16{8'(i * 17)}};
      rom_ct[0][i]  = model_aes(rom_key[0][i], rom_pt[0][i], 1'b0);
      rom_key[2][i] = rom_key[0][i];
      rom_pt[2][i]  = rom_pt[0][i];
      rom_ct[2][i]  = rom_ct[0][i];
      rom_key[1][i] = FIPS_K128;
      rom_pt[1][i]  = FIPS_PT;
      rom_ct[1][i]  = FIPS_CT128;
    end
    rom_ct[0][0] = FIPS_CT256;
    rom_ct[2][0] = FIPS_CT256;

    repeat (3) @(posedge clk);
    #1;
    checkResetState("por");
    checkOutput("mode_b", core_mode[1], 2'd0);
    checkOutput("core_reset_b", core_reset[1], 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    #1 checkOutput("core_reset_hold", core_reset[0], 1'b1);
    @(posedge clk);
    #1 checkOutput("core_reset_release", core_reset[0], 1'b0);

    $display("[TB] all-good ROM, KEY_W=256, done on last WAIT cycle");
    applyStimulus(mkExp(0, 1'b1, 0, 0, 1'b0, 1'b0, 8, 3));
    waitResult(0);

    $display("[TB] KEY_W=128 single vector");
    applyStimulus(mkExp(1, 1'b1, 0, 0, 1'b0, 1'b0, 2, 0));
    waitResult(1);
    checkOutput("b_key_hi", core_key[1][255:128], 0);
    checkOutput("b_core_key", core_key[1], FIPS_K128);

    $display("[TB] vector 2 ct corrupted, run to completion");
    rom_ct[0][2] = rom_ct[0][2] ^ 128'h1;
    rom_ct[2][2] = rom_ct[2][2] ^ 128'h1;
    applyStimulus(mkExp(0, 1'b0, 2, 2, 1'b0, 1'b0, 8, 3));
    waitResult(0);

    $display("[TB] vector 2 ct corrupted, stop on first failure");
    applyStimulus(mkExp(2, 1'b0, 1, 2, 1'b0, 1'b0, 5, 2));
    waitResult(2);

    $display("[TB] hung core, TIMEOUT=8");
    rom_ct[0][2] = rom_ct[0][2] ^ 128'h1;
    hang[0] = 1'b1;
    applyStimulus(mkExp(0, 1'b0, 4, 0, 1'b0, 1'b1, 4, 3));
    waitResult(0);
    checkOutput("wdog_start_gap", gap[0], 13);
    hang[0] = 1'b0;

    $display("[TB] reset during WAIT, then rerun with ignored run pulse");
    applyStimulus(mkExp(0, 1'b1, 0, 0, 1'b0, 1'b0, 8, 3));
    n = 0;
    while (core_start[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cstart_seen", core_start[0], 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 checkResetState("wait_rst");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(mkExp(0, 1'b1, 0, 0, 1'b0, 1'b0, 8, 3));
    repeat (20) @(posedge clk);
    #1 run[0] = 1'b1;
    @(posedge clk);
    #1 run[0] = 1'b0;
    waitResult(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
